// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode constants and FSM state encoding for seq_alu.
//   OP_*    : values of the 3-bit Cntrl opcode (5..7 are illegal)
//   state_t : top-level control state (idle / multiply in flight)
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_XOR = 3'd2;
  localparam logic [2:0] OP_SLT = 3'd3;
  localparam logic [2:0] OP_MUL = 3'd4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/seq_alu_if.sv
// seq_alu_if: request/result bundle of the sequential ALU.
//   in_valid/in_ready : request handshake, Cntrl/A/B : opcode and operands
//   out_valid         : one-cycle result strobe
//   Out/OutHi         : result (OutHi = upper product half for MUL)
//   Cout/Ovf/Zero/Err : result flags
// master = requester side, slave = ALU side.
interface seq_alu_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       Cntrl;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             out_valid;
  logic [WIDTH-1:0] Out;
  logic [WIDTH-1:0] OutHi;
  logic             Cout;
  logic             Ovf;
  logic             Zero;
  logic             Err;

  modport master (
    output in_valid, Cntrl, A, B,
    input  in_ready, out_valid, Out, OutHi, Cout, Ovf, Zero, Err
  );

  modport slave (
    input  in_valid, Cntrl, A, B,
    output in_ready, out_valid, Out, OutHi, Cout, Ovf, Zero, Err
  );
endinterface

// File: rtl/seq_mul.sv
// seq_mul: iterative unsigned shift-add multiplier, one partial product
// per clock.
//   clk, reset : clock, synchronous active-high reset
//   start      : load operands A/B (ignored while busy)
//   busy       : iteration in progress
//   done       : the coming edge performs the final iteration
//   P          : product as it will stand after the coming edge; equals
//                A*B in the cycle where done is high
module seq_mul #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] P
);

  // acc = {partial product high half, remaining multiplier bits / low half}
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               busy_q;
  logic [2*WIDTH-1:0] start_acc;
  logic [2*WIDTH-1:0] run_acc;

  // One iteration: conditionally add the multiplicand into the upper half
  // (WIDTH+1 bits keeps the carry), then shift the whole accumulator right.
  function automatic logic [2*WIDTH-1:0] step(input logic [2*WIDTH-1:0] acc,
                                               input logic [WIDTH-1:0]   mc);
    logic [WIDTH:0] sum;
    sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? mc : {WIDTH{1'b0}})};
    step = {sum, acc[WIDTH-1:1]};
  endfunction

  // The first iteration is folded into the load edge (product=0,
  // multiplier=B), so WIDTH iterations finish WIDTH-1 edges after start.
  assign start_acc = step({{WIDTH{1'b0}}, B}, A);
  assign run_acc   = step(acc_q, mcand_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q   <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else if (busy_q) begin
      acc_q <= run_acc;
      cnt_q <= cnt_q + CNT_W'(1);
      if (cnt_q == CNT_W'(WIDTH - 1)) begin
        busy_q <= 1'b0;
      end
    end else if (start) begin
      acc_q   <= start_acc;
      mcand_q <= A;
      cnt_q   <= CNT_W'(1);
      busy_q  <= 1'b1;
    end
  end

  assign busy = busy_q;
  assign done = busy_q && (cnt_q == CNT_W'(WIDTH - 1));
  assign P    = run_acc;

endmodule

// File: rtl/seq_alu.sv
// seq_alu: registered WIDTH-bit ALU (ADD, SUB, XOR, SLT, MUL) with a
// valid/ready request port and a one-cycle out_valid result strobe.
//   clk, reset : clock, synchronous active-high reset
//   bus        : seq_alu_if.slave (handshake, operands, result, flags)
// Non-MUL ops give their result the cycle after accept; MUL runs on
// seq_mul and delivers its result WIDTH cycles after accept.
//
// state   | meaning
// --------+-----------------------------------------------------
// ST_IDLE | in_ready=1; accepts any op, single-cycle ops complete here
// ST_MUL  | multiply iterating; in_ready=0, in_valid ignored
module seq_alu #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic      clk,
  input  logic      reset,
  seq_alu_if.slave  bus
);
  import alu_pkg::*;

  state_t             state_q, state_d;
  logic               accept;
  logic               mul_start;
  logic               mul_busy;
  logic               mul_done;
  logic               mul_fin;
  logic [2*WIDTH-1:0] mul_p;

  logic [WIDTH:0]     add_full;
  logic [WIDTH:0]     sub_full;
  logic               add_ovf;
  logic               sub_ovf;
  logic               slt_lt;

  logic               res_load;
  logic [WIDTH-1:0]   res_out;
  logic [WIDTH-1:0]   res_hi;
  logic               res_cout;
  logic               res_ovf;
  logic               res_err;

  assign bus.in_ready = (state_q == ST_IDLE);
  assign accept       = bus.in_valid && (state_q == ST_IDLE);
  assign mul_start    = accept && (bus.Cntrl == OP_MUL);
  assign mul_fin      = (state_q == ST_MUL) && mul_busy && mul_done;

  seq_mul #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_mul (
    .clk   (clk),
    .reset (reset),
    .start (mul_start),
    .A     (bus.A),
    .B     (bus.B),
    .busy  (mul_busy),
    .done  (mul_done),
    .P     (mul_p)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (mul_start) state_d = ST_MUL;
      ST_MUL:  if (mul_fin)   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Single-cycle datapath; SUB is A + ~B + 1 so Cout=1 means no borrow.
  assign add_full = {1'b0, bus.A} + {1'b0, bus.B};
  assign sub_full = {1'b0, bus.A} + {1'b0, ~bus.B} + {{WIDTH{1'b0}}, 1'b1};
  assign add_ovf  = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) &&
                    (add_full[WIDTH-1] != bus.A[WIDTH-1]);
  assign sub_ovf  = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) &&
                    (sub_full[WIDTH-1] != bus.A[WIDTH-1]);
  // Sign of the difference, corrected when the subtraction overflowed.
  assign slt_lt   = sub_full[WIDTH-1] ^ sub_ovf;

  always_comb begin
    res_load = 1'b0;
    res_out  = '0;
    res_hi   = '0;
    res_cout = 1'b0;
    res_ovf  = 1'b0;
    res_err  = 1'b0;
    if (state_q == ST_MUL) begin
      res_load = mul_fin;
      res_out  = mul_p[WIDTH-1:0];
      res_hi   = mul_p[2*WIDTH-1:WIDTH];
    end else if (accept && (bus.Cntrl != OP_MUL)) begin
      res_load = 1'b1;
      case (bus.Cntrl)
        OP_ADD: begin
          res_out  = add_full[WIDTH-1:0];
          res_cout = add_full[WIDTH];
          res_ovf  = add_ovf;
        end
        OP_SUB: begin
          res_out  = sub_full[WIDTH-1:0];
          res_cout = sub_full[WIDTH];
          res_ovf  = sub_ovf;
        end
        OP_XOR:  res_out = bus.A ^ bus.B;
        OP_SLT:  res_out = {{(WIDTH-1){1'b0}}, slt_lt};
        default: res_err = 1'b1;
      endcase
    end
  end

  // Result and flags hold between results; out_valid is a single pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.out_valid <= 1'b0;
      bus.Out       <= '0;
      bus.OutHi     <= '0;
      bus.Cout      <= 1'b0;
      bus.Ovf       <= 1'b0;
      bus.Zero      <= 1'b1;
      bus.Err       <= 1'b0;
    end else begin
      bus.out_valid <= res_load;
      if (res_load) begin
        bus.Out   <= res_out;
        bus.OutHi <= res_hi;
        bus.Cout  <= res_cout;
        bus.Ovf   <= res_ovf;
        bus.Zero  <= (res_out == '0);
        bus.Err   <= res_err;
      end
    end
  end

endmodule
